// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the single-port memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT, RESP)
//   arb_owner_t : which requester owns / won the memory (fetch or data)
//   CNT_W       : width of the read-latency counter (RD_LAT is at most 7)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational two-requester selector for the memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin; on conflict the requester not granted last wins
//   undefined : fixed priority, data over fetch (last_i is ignored)
// Ports:
//   ireq_i   : fetch request
//   dreq_i   : data request
//   last_i   : requester granted most recently
//   winner_o : selected requester (meaningful only when valid_o is high)
//   valid_o  : at least one request is pending
// -----------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ireq_i,
    input  logic       dreq_i,
    input  arb_owner_t last_i,
    output arb_owner_t winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = ireq_i | dreq_i;
`ifdef MEM_ARB_RR_EN
        if (ireq_i && dreq_i) begin
            winner_o = (last_i == OWN_D) ? OWN_I : OWN_D;
        end else begin
            winner_o = dreq_i ? OWN_D : OWN_I;
        end
`else
        winner_o = dreq_i ? OWN_D : OWN_I;
`endif
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority has no use for the history input.
    logic unused_last;
    assign unused_last = (last_i == OWN_D);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between the instruction-fetch requester and
// the load/store requester. One transaction in flight at a time; stores
// complete on issue, reads return after RD_LAT cycles with a one-cycle strobe.
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of data priority).
// Parameters:
//   ADDR_W, DATA_W : address / data widths
//   RD_LAT         : memory read latency, issue cycle to mem_rdata valid (1..7)
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   i_req/i_addr                : fetch request and address
//   i_ack/i_rvalid/i_rdata      : fetch accepted, fetch data strobe and data
//   d_req/d_we/d_addr/d_wdata   : data request (d_we=1 store, 0 load)
//   d_ack/d_rvalid/d_rdata      : data accepted, load data strobe and data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory macro pins
//   busy                        : a read is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RD_LAT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    arb_owner_t        owner_q, owner_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;

    arb_owner_t        last_own;
    arb_owner_t        winner;
    logic              gnt_valid;
    logic              issue;
    logic              win_d;
    logic              rd_issue;
    logic              capture;

`ifdef MEM_ARB_RR_EN
    // Requester granted most recently; every grant updates it, contested or not.
    arb_owner_t last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_D;
        end else if (issue) begin
            last_q <= winner;
        end
    end

    assign last_own = last_q;
`else
    assign last_own = OWN_D;
`endif

    arb_pick u_pick (
        .ireq_i   (i_req),
        .dreq_i   (d_req),
        .last_i   (last_own),
        .winner_o (winner),
        .valid_o  (gnt_valid)
    );

    // Issue is allowed in IDLE and RESP; reset forces every output quiet.
    assign issue    = !rst && (state_q != WAIT) && gnt_valid;
    assign win_d    = (winner == OWN_D);
    assign rd_issue = issue && !(win_d && d_we);
    assign capture  = (state_q == WAIT) && (cnt_q == LAT_C);

    assign i_ack     = issue && !win_d;
    assign d_ack     = issue && win_d;
    assign mem_en    = issue;
    assign mem_we    = issue && win_d && d_we;
    assign mem_addr  = issue ? (win_d ? d_addr : i_addr) : '0;
    assign mem_wdata = (issue && win_d) ? d_wdata : '0;

    assign busy     = !rst && (state_q == WAIT);
    assign i_rvalid = !rst && i_rvalid_q;
    assign d_rvalid = !rst && d_rvalid_q;
    assign i_rdata  = rst ? '0 : i_rdata_q;
    assign d_rdata  = rst ? '0 : d_rdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        case (state_q)
            WAIT: begin
                if (capture) begin
                    // The strobe is registered, so it lands in the RESP cycle.
                    state_d = RESP;
                    cnt_d   = '0;
                    if (owner_q == OWN_I) begin
                        i_rdata_d  = mem_rdata;
                        i_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and RESP arbitrate identically; stores never leave IDLE.
                if (rd_issue) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                    owner_d = winner;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_I;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Stimulus pushes expected acks and read
// responses into queues; a negedge monitor pops and compares them whenever
// the DUT raises an ack or rvalid. Two extra instances (RD_LAT=1 and 7)
// run back-to-back fetches to check response spacing.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: two preset words, otherwise a small RAM written by stores.
    logic [DW-1:0] mem  [0:255];
    logic [DW-1:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_en && !mem_we)
            pipe[0] <= (mem_addr == 32'h40) ? 32'hDEADBEEF :
                       (mem_addr == 32'h44) ? 32'hCAFEF00D : mem[mem_addr[9:2]];
        else
            pipe[0] <= '0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // Sweep instances
    logic          sw_rst, sw_req, zero1;
    logic [AW-1:0] zero_a;
    logic [DW-1:0] zero_d, sw_rd1, sw_rd7;
    logic          l1_ack, l1_rv, l1_dack, l1_drv, l1_en, l1_we, l1_busy;
    logic [DW-1:0] l1_rd, l1_drd, l1_wd;
    logic [AW-1:0] l1_a;
    logic          l7_ack, l7_rv, l7_dack, l7_drv, l7_en, l7_we, l7_busy;
    logic [DW-1:0] l7_rd, l7_drd, l7_wd;
    logic [AW-1:0] l7_a;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_l1 (
        .clk(clk), .rst(sw_rst),
        .i_req(sw_req), .i_addr(zero_a), .i_ack(l1_ack), .i_rvalid(l1_rv), .i_rdata(l1_rd),
        .d_req(zero1), .d_we(zero1), .d_addr(zero_a), .d_wdata(zero_d),
        .d_ack(l1_dack), .d_rvalid(l1_drv), .d_rdata(l1_drd),
        .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_a), .mem_wdata(l1_wd),
        .mem_rdata(sw_rd1), .busy(l1_busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(7)) u_l7 (
        .clk(clk), .rst(sw_rst),
        .i_req(sw_req), .i_addr(zero_a), .i_ack(l7_ack), .i_rvalid(l7_rv), .i_rdata(l7_rd),
        .d_req(zero1), .d_we(zero1), .d_addr(zero_a), .d_wdata(zero_d),
        .d_ack(l7_dack), .d_rvalid(l7_drv), .d_rdata(l7_drd),
        .mem_en(l7_en), .mem_we(l7_we), .mem_addr(l7_a), .mem_wdata(l7_wd),
        .mem_rdata(sw_rd7), .busy(l7_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            c;
        logic          port;
        logic [DW-1:0] data;
    } ev_t;

    ev_t ack_q[$];
    ev_t rsp_q[$];

    task automatic push_ack(input int c, input logic p);
        ev_t e;
        e.c = c; e.port = p; e.data = '0;
        ack_q.push_back(e);
    endtask

    task automatic push_rsp(input int c, input logic p, input logic [DW-1:0] v);
        ev_t e;
        e.c = c; e.port = p; e.data = v;
        rsp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (i_ack || d_ack) begin
                checks++;
                if (i_ack && d_ack) begin
                    errors++;
                    $display("FAIL ack_both: got both acks at cyc=%0d, required one", cyc);
                end else if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_extra: got ack port=%0d at cyc=%0d, required none", d_ack, cyc);
                end else begin
                    ev_t a;
                    a = ack_q.pop_front();
                    $display("ack cyc=%0d port=%s", cyc, d_ack ? "D" : "I");
                    if (a.c != cyc || a.port != d_ack) begin
                        errors++;
                        $display("FAIL ack_seq: got cyc=%0d port=%0d, required cyc=%0d port=%0d",
                                 cyc, d_ack, a.c, a.port);
                    end
                end
            end
            if (i_rvalid || d_rvalid) begin
                checks++;
                if (i_rvalid && d_rvalid) begin
                    errors++;
                    $display("FAIL rvalid_both: got both rvalids at cyc=%0d, required one", cyc);
                end else if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_extra: got rvalid port=%0d at cyc=%0d, required none", d_rvalid, cyc);
                end else begin
                    ev_t r;
                    logic [DW-1:0] got;
                    r = rsp_q.pop_front();
                    got = d_rvalid ? d_rdata : i_rdata;
                    $display("rsp cyc=%0d port=%s data=%h", cyc, d_rvalid ? "D" : "I", got);
                    if (r.c != cyc || r.port != d_rvalid || r.data !== got) begin
                        errors++;
                        $display("FAIL rsp_seq: got cyc=%0d port=%0d data=%h, required cyc=%0d port=%0d data=%h",
                                 cyc, d_rvalid, got, r.c, r.port, r.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    int base;
    int prev1, prev7, cnt1, cnt7;

    initial begin
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = '0;
        sw_rst = 1'b1; sw_req = 1'b0; zero1 = 1'b0; zero_a = '0; zero_d = '0;
        sw_rd1 = 32'h11110001; sw_rd7 = 32'h77770007;

        // Reset with both requests present: everything must stay quiet.
        repeat (3) step();
        at_neg();
        check("rst_i_ack", {31'd0, i_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
        step();
        rst = 1'b0;
        at_neg();
        check("post_rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("post_rst_rdata", i_rdata, 32'd0);
        step();

        // Single fetch
        base = cyc;
        i_req = 1'b1; i_addr = 32'h40;
        push_ack(base, 1'b0);
        push_rsp(base + 3, 1'b0, 32'hDEADBEEF);
        at_neg();
        check("f_mem_en", {31'd0, mem_en}, 32'd1);
        check("f_mem_addr", mem_addr, 32'h40);
        check("f_mem_we", {31'd0, mem_we}, 32'd0);
        step();
        i_req = 1'b0; i_addr = '0;
        at_neg(); check("f_busy1", {31'd0, busy}, 32'd1); step();
        at_neg(); check("f_busy2", {31'd0, busy}, 32'd1); step();
        at_neg(); check("f_busy3", {31'd0, busy}, 32'd0); step();
        at_neg();
        check("f_rdata_hold", i_rdata, 32'hDEADBEEF);
        check("f_idle_addr", mem_addr, 32'd0);
        step();

        // Store then load from the same address
        base = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234;
        push_ack(base, 1'b1);
        at_neg();
        check("st_mem_we", {31'd0, mem_we}, 32'd1);
        check("st_mem_addr", mem_addr, 32'h100);
        check("st_mem_wdata", mem_wdata, 32'h1234);
        step();
        d_we = 1'b0; d_wdata = '0;
        push_ack(base + 1, 1'b1);
        push_rsp(base + 4, 1'b1, 32'h1234);
        at_neg();
        check("ld_mem_we", {31'd0, mem_we}, 32'd0);
        check("ld_mem_en", {31'd0, mem_en}, 32'd1);
        step();
        d_req = 1'b0; d_addr = '0;
        repeat (3) begin at_neg(); step(); end
        check("ld_rdata_hold", d_rdata, 32'h1234);

        // Back-to-back stores, one per cycle
        base = cyc;
        for (int k = 0; k < 2; k++) begin
            d_req = 1'b1; d_we = 1'b1;
            d_addr = 32'h104 + 32'(4 * k); d_wdata = 32'h5555 + 32'(k);
            push_ack(base + k, 1'b1);
            at_neg();
            check("bb_mem_we", {31'd0, mem_we}, 32'd1);
            check("bb_mem_wdata", mem_wdata, 32'h5555 + 32'(k));
            step();
        end
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        at_neg(); step();

        // Simultaneous fetch and load held from reset release
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h40; d_addr = 32'h100;
        step();
        at_neg(); check("rst2_i_ack", {31'd0, i_ack}, 32'd0);
        step();
        rst = 1'b0;
        base = cyc;
`ifdef MEM_ARB_RR_EN
        push_ack(base, 1'b0); push_ack(base + 3, 1'b1); push_ack(base + 6, 1'b0);
        push_rsp(base + 3, 1'b0, 32'hDEADBEEF);
        push_rsp(base + 6, 1'b1, 32'h1234);
        push_rsp(base + 9, 1'b0, 32'hDEADBEEF);
`else
        push_ack(base, 1'b1); push_ack(base + 3, 1'b0); push_ack(base + 6, 1'b0);
        push_rsp(base + 3, 1'b1, 32'h1234);
        push_rsp(base + 6, 1'b0, 32'hDEADBEEF);
        push_rsp(base + 9, 1'b0, 32'hDEADBEEF);
`endif
        for (int k = 0; k < 11; k++) begin
            i_req = (k <= 6);
`ifdef MEM_ARB_RR_EN
            d_req = (k <= 3);
`else
            d_req = (k == 0);
`endif
            at_neg();
            step();
        end
        i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;

        // Reset during an outstanding read
        base = cyc;
        i_req = 1'b1; i_addr = 32'h40;
        push_ack(base, 1'b0);
        at_neg(); step();
        i_req = 1'b0; rst = 1'b1;
        at_neg(); check("mr_busy_rst", {31'd0, busy}, 32'd0); step();
        rst = 1'b0;
        at_neg(); check("mr_busy_after", {31'd0, busy}, 32'd0); step();
        i_req = 1'b1; i_addr = 32'h44;
        push_ack(base + 3, 1'b0);
        push_rsp(base + 6, 1'b0, 32'hCAFEF00D);
        at_neg(); step();
        i_req = 1'b0; i_addr = '0;
        repeat (4) begin at_neg(); step(); end

        // Latency sweep: back-to-back fetches on RD_LAT=1 and RD_LAT=7
        sw_req = 1'b1; sw_rst = 1'b0;
        prev1 = 0; prev7 = 0; cnt1 = 0; cnt7 = 0;
        for (int k = 0; k < 40; k++) begin
            at_neg();
            if (l1_rv) begin
                check("l1_spacing", 32'(k - prev1), 32'd2);
                check("l1_rdata", l1_rd, 32'h11110001);
                prev1 = k; cnt1++;
            end
            if (l7_rv) begin
                check("l7_spacing", 32'(k - prev7), 32'd8);
                check("l7_rdata", l7_rd, 32'h77770007);
                prev7 = k; cnt7++;
            end
            if (l1_busy) check("l1_ack_in_wait", {31'd0, l1_ack}, 32'd0);
            if (l7_busy) check("l7_ack_in_wait", {31'd0, l7_ack}, 32'd0);
            step();
        end
        $display("sweep rvalids: lat1=%0d lat7=%0d", cnt1, cnt7);
        check("l1_count", 32'(cnt1), 32'd19);
        check("l7_count", 32'(cnt7), 32'd4);

        check("ack_q_drained", 32'(ack_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
